// File: rtl/cpu_defs_pkg.sv
// Shared decoder encodings and control bundle for the 5-stage core.
// Used by the ID, EX and MEM stage registers.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic ALUSRC2_REG     = 1'b0;
  localparam logic ALUSRC2_IMMED   = 1'b1;
  localparam logic REG_W1_ADDR_RT  = 1'b0;
  localparam logic REG_W1_ADDR_RD  = 1'b1;
  localparam logic REG_W1_DATA_ALU = 1'b0;
  localparam logic REG_W1_DATA_DM  = 1'b1;

  typedef struct packed {
    logic       branch;
    logic       DM_read;
    logic       DM_write;
    logic       reg_write;
    logic       ALU_src2_sel;
    logic       reg_w1_addr_sel;
    logic       reg_w1_data_sel;
    logic [5:0] ALU_op;
  } ctrl_bundle_t;

  function automatic logic op_uses_rs(input logic [5:0] op);
    unique case (op)
      OP_RTYPE, OP_ADDI, OP_ORI,
      OP_BEQ, OP_LW, OP_SW: op_uses_rs = 1'b1;
      default:              op_uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rt(input logic [5:0] op);
    unique case (op)
      OP_RTYPE, OP_BEQ, OP_SW: op_uses_rt = 1'b1;
      default:                 op_uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_hazard_det.sv
// Load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently sitting in EX.
module load_use_hazard_det
  import cpu_defs_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_DM_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
  input  logic                  id_valid_i,
  input  logic [5:0]            id_op_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic                  hazard_o
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_ex_load;

  assign w_ex_load = ex_valid_i & ex_DM_read_i
                   & (ex_rt_addr_i != '0);

  assign w_rs_hit = op_uses_rs(id_op_i)
                  & (ex_rt_addr_i == rs_addr_i);

  assign w_rt_hit = op_uses_rt(id_op_i)
                  & (ex_rt_addr_i == rt_addr_i);

  assign hazard_o = w_ex_load & id_valid_i
                  & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion,
// branch squash and a saturating stall-cycle counter.
module id_ex_pipe_reg
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  input  logic [5:0]             id_op_i,
  input  logic                   ALU_src2_sel_i,
  input  logic                   reg_w1_addr_sel_i,
  input  logic                   reg_w1_data_sel_i,
  input  logic                   branch_i,
  input  logic                   DM_read_i,
  input  logic                   DM_write_i,
  input  logic                   reg_write_i,
  input  logic [5:0]             ALU_op_i,
  input  logic [DATA_W-1:0]      pc_plus4_i,
  input  logic [DATA_W-1:0]      rs_data_i,
  input  logic [DATA_W-1:0]      rt_data_i,
  input  logic [DATA_W-1:0]      immed_i,
  input  logic [REG_ADDR_W-1:0]  rs_addr_i,
  input  logic [REG_ADDR_W-1:0]  rt_addr_i,
  input  logic [REG_ADDR_W-1:0]  rd_addr_i,
  input  logic [5:0]             funct_i,
  output logic                   ex_valid_o,
  output logic                   ex_ALU_src2_sel_o,
  output logic                   ex_reg_w1_addr_sel_o,
  output logic                   ex_reg_w1_data_sel_o,
  output logic                   ex_branch_o,
  output logic                   ex_DM_read_o,
  output logic                   ex_DM_write_o,
  output logic                   ex_reg_write_o,
  output logic [5:0]             ex_ALU_op_o,
  output logic [DATA_W-1:0]      ex_pc_plus4_o,
  output logic [DATA_W-1:0]      ex_rs_data_o,
  output logic [DATA_W-1:0]      ex_rt_data_o,
  output logic [DATA_W-1:0]      ex_immed_o,
  output logic [REG_ADDR_W-1:0]  ex_rs_addr_o,
  output logic [REG_ADDR_W-1:0]  ex_rt_addr_o,
  output logic [REG_ADDR_W-1:0]  ex_rd_addr_o,
  output logic [5:0]             ex_funct_o,
  output logic                   hold_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  ctrl_bundle_t            w_ctrl_in;
  ctrl_bundle_t            r_ctrl;
  logic                    r_valid;
  logic [DATA_W-1:0]       r_pc_plus4;
  logic [DATA_W-1:0]       r_rs_data;
  logic [DATA_W-1:0]       r_rt_data;
  logic [DATA_W-1:0]       r_immed;
  logic [REG_ADDR_W-1:0]   r_rs_addr;
  logic [REG_ADDR_W-1:0]   r_rt_addr;
  logic [REG_ADDR_W-1:0]   r_rd_addr;
  logic [5:0]              r_funct;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    w_hazard;
  logic                    w_bubble;

  assign w_ctrl_in = '{
    branch:          branch_i,
    DM_read:         DM_read_i,
    DM_write:        DM_write_i,
    reg_write:       reg_write_i,
    ALU_src2_sel:    ALU_src2_sel_i,
    reg_w1_addr_sel: reg_w1_addr_sel_i,
    reg_w1_data_sel: reg_w1_data_sel_i,
    ALU_op:          ALU_op_i
  };

  load_use_hazard_det #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_valid_i   (r_valid),
    .ex_DM_read_i (r_ctrl.DM_read),
    .ex_rt_addr_i (r_rt_addr),
    .id_valid_i   (id_valid_i),
    .id_op_i      (id_op_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .hazard_o     (w_hazard)
  );

  // Flush outranks the hazard so PC is free to take the branch target.
  assign hold_o   = w_hazard & ~flush_i;
  assign w_bubble = flush_i | w_hazard;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_pc_plus4  <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_immed     <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_funct     <= '0;
      r_stall_cnt <= '0;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_pc_plus4  <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_immed     <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_funct     <= '0;
      if (hold_o && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end else begin
      r_valid     <= id_valid_i;
      r_ctrl      <= w_ctrl_in;
      r_pc_plus4  <= pc_plus4_i;
      r_rs_data   <= rs_data_i;
      r_rt_data   <= rt_data_i;
      r_immed     <= immed_i;
      r_rs_addr   <= rs_addr_i;
      r_rt_addr   <= rt_addr_i;
      r_rd_addr   <= rd_addr_i;
      r_funct     <= funct_i;
    end
  end

  assign ex_valid_o           = r_valid;
  assign ex_ALU_src2_sel_o    = r_ctrl.ALU_src2_sel;
  assign ex_reg_w1_addr_sel_o = r_ctrl.reg_w1_addr_sel;
  assign ex_reg_w1_data_sel_o = r_ctrl.reg_w1_data_sel;
  assign ex_branch_o          = r_ctrl.branch;
  assign ex_DM_read_o         = r_ctrl.DM_read;
  assign ex_DM_write_o        = r_ctrl.DM_write;
  assign ex_reg_write_o       = r_ctrl.reg_write;
  assign ex_ALU_op_o          = r_ctrl.ALU_op;
  assign ex_pc_plus4_o        = r_pc_plus4;
  assign ex_rs_data_o         = r_rs_data;
  assign ex_rt_data_o         = r_rt_data;
  assign ex_immed_o           = r_immed;
  assign ex_rs_addr_o         = r_rs_addr;
  assign ex_rt_addr_o         = r_rt_addr;
  assign ex_rd_addr_o         = r_rd_addr;
  assign ex_funct_o           = r_funct;
  assign stall_cnt_o          = r_stall_cnt;

endmodule
